// File: rtl/alu_bist_driver.sv
// alu_bist_driver: BIST initiator for the execute-stage ALU.
// It sweeps LFSR operand pairs across every opSel code and folds each ALU
// response into a 32-bit MISR. At the end of the run it compares the
// signature against a golden value.
module alu_bist_driver #(
  parameter int unsigned        DATA_WIDTH   = 32,
  parameter int unsigned        SEL_WIDTH    = 3,
  parameter int unsigned        NUM_OPS      = 5,
  parameter int unsigned        NUM_PATTERNS = 256,
  parameter logic [31:0]        SEED_A       = 32'hACE1_1234,
  parameter logic [31:0]        SEED_B       = 32'h1357_9BDF,
  parameter logic [31:0]        GOLDEN_SIG   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [DATA_WIDTH-1:0] alu_operand1,
  output logic [DATA_WIDTH-1:0] alu_operand2,
  output logic [SEL_WIDTH-1:0]  alu_opSel,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_zero,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [31:0]           signature,
  output logic [15:0]           pattern_count
);

  // Fixed 32-bit polynomials for the operand generators and the compactor.
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam logic [31:0] MISR_POLY = 32'h0040_0007;

  // An all-zero seed would lock the LFSR at zero, so it is replaced by 1.
  localparam logic [31:0] SEED_A_EFF = (SEED_A == 32'h0) ? 32'h1 : SEED_A;
  localparam logic [31:0] SEED_B_EFF = (SEED_B == 32'h0) ? 32'h1 : SEED_B;

  localparam logic [SEL_WIDTH-1:0] LAST_OP  = SEL_WIDTH'(NUM_OPS - 1);
  localparam logic [15:0]          LAST_PAT = 16'(NUM_PATTERNS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   op1_q, op1_d;
  logic [DATA_WIDTH-1:0]   op2_q, op2_d;
  logic [SEL_WIDTH-1:0]    opsel_q, opsel_d;
  logic [15:0]             pcnt_q, pcnt_d;
  logic [31:0]             misr_q, misr_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    pass_q, pass_d;

  logic [31:0]             misr_capture;
  logic                    last_vector;

  // Galois right-shift LFSR step.
  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    lfsr_step = (l >> 1) ^ (l[0] ? LFSR_MASK : 32'h0);
  endfunction

  // Fold the ALU response of the vector driven last cycle into the MISR.
  // The zero flag is merged into the top bit of the result word.
  always_comb begin
    misr_capture = {misr_q[30:0], 1'b0}
                 ^ (misr_q[31] ? MISR_POLY : 32'h0)
                 ^ (alu_result ^ {alu_zero, 31'b0});
  end

  assign last_vector = (pcnt_q == LAST_PAT) && (opsel_q == LAST_OP);

  // Next-state and datapath control; everything holds by default.
  always_comb begin
    state_d = state_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    opsel_d = opsel_q;
    pcnt_d  = pcnt_q;
    misr_d  = misr_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          op1_d   = SEED_A_EFF;
          op2_d   = SEED_B_EFF;
          opsel_d = '0;
          pcnt_d  = '0;
          misr_d  = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end

      ST_RUN: begin
        misr_d = misr_capture;
        if (last_vector) begin
          // Operands, opSel and pattern index freeze on the final vector.
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (misr_capture == GOLDEN_SIG);
        end else if (opsel_q != LAST_OP) begin
          opsel_d = opsel_q + 1'b1;
        end else begin
          opsel_d = '0;
          op1_d   = lfsr_step(op1_q);
          op2_d   = lfsr_step(op2_q);
          pcnt_d  = pcnt_q + 16'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any run immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op1_q   <= '0;
      op2_q   <= '0;
      opsel_q <= '0;
      pcnt_q  <= '0;
      misr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      opsel_q <= opsel_d;
      pcnt_q  <= pcnt_d;
      misr_q  <= misr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign alu_operand1  = op1_q;
  assign alu_operand2  = op2_q;
  assign alu_opSel     = opsel_q;
  assign pattern_count = pcnt_q;
  assign signature     = misr_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;

endmodule

// File: doc/alu_bist_driver.md
Name: alu_bist_driver

Overview:
Built-in self-test initiator for the execute-stage ALU. It drives pseudo-random operand pairs and every opSel code into the combinational ALU, then compresses each returned result/zero pair into a multiple-input signature register (MISR). At the end of the run it compares the signature with a golden value and reports pass/fail. It sits beside the ALU behind a test mux and owns the ALU's input side while a test runs.

Parameters:
DATA_WIDTH, 32, operand/result width; only 32 is supported (LFSR/MISR polynomials are fixed for 32 bits)
SEL_WIDTH, 3, opSel width
NUM_OPS, 5, opSel codes exercised per pattern (0..NUM_OPS-1: ADD, SUB, AND, OR, SLT)
NUM_PATTERNS, 256, operand pairs per run (>=1)
SEED_A, 32'hACE1_1234, operand1 LFSR seed (zero is replaced by 1)
SEED_B, 32'h1357_9BDF, operand2 LFSR seed (zero is replaced by 1)
GOLDEN_SIG, 32'h0000_0000, expected final signature

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; starts a run from IDLE or DONE
alu_operand1  output  DATA_WIDTH  to ALU operand1
alu_operand2  output  DATA_WIDTH  to ALU operand2
alu_opSel  output  SEL_WIDTH  to ALU opSel
alu_result  input  DATA_WIDTH  from ALU result
alu_zero  input  1  from ALU zero
busy  output  1  high while in RUN
done  output  1  high in DONE
pass  output  1  valid when done; signature == GOLDEN_SIG
signature  output  32  current MISR contents
pattern_count  output  16  index of the operand pair being driven

Behaviour:
- All outputs are registered. rst_n low (async) -> state IDLE; operands, opSel, signature, pattern_count, busy, done and pass all 0.
- FSM states IDLE, RUN, DONE.
- IDLE/DONE + start at edge T -> RUN. operand1=SEED_A, operand2=SEED_B, opSel=0, pattern_count=0, MISR=0, done=0, pass=0, busy=1.
- RUN, at each edge: capture the ALU response to the vector driven during the previous cycle (the ALU is combinational, so response latency is 0). MISR_next = {M[30:0],1'b0} ^ (M[31] ? 32'h0040_0007 : 0) ^ (alu_result ^ {alu_zero,31'b0}).
- RUN vector advance: if opSel < NUM_OPS-1, increment opSel. Otherwise set opSel=0, step both LFSRs and increment pattern_count.
- LFSR step: Galois right shift, mask 32'h8020_0003. next = (L>>1) ^ (L[0] ? mask : 0).
- Last vector is pattern_count==NUM_PATTERNS-1 with opSel==NUM_OPS-1. On its capture edge (T + NUM_PATTERNS*NUM_OPS): state -> DONE, busy=0, done=1, pass=(MISR_next==GOLDEN_SIG). Operands, opSel and pattern_count freeze.
- start during RUN: ignored. start in DONE: restarts exactly as from IDLE.
- DONE holds signature, pass and done until start or reset.
- Outside RUN, operands and opSel hold their last value (0 after reset).
- Reset mid-run: immediate abort to IDLE values; no partial result is retained.

Test Plan:
1. Reset asserted with start toggling -> all outputs 0, state stays IDLE. Release reset with no start -> no change.
2. NUM_PATTERNS=1, SEED_A=SEED_B=1, real ALU, start -> opSel 0,1,2,3,4 on five consecutive cycles with operands 1/1; done at T+5; signature=32'h8100_003A.
3. As scenario 2 with GOLDEN_SIG=32'h8100_003A -> pass=1. With the ALU model's zero forced to 0 -> signature != 32'h8100_003A and pass=0.
4. NUM_PATTERNS=2, seeds 1 -> from cycle 5 both operands = 32'h8020_0003 and pattern_count=1; done at T+10.
5. start pulses at cycles 2 and 4 of a run -> ignored, done still at T+5*NUM_PATTERNS. start in DONE -> MISR cleared, new run yields an identical signature.
6. rst_n pulled low at cycle 3 of a run -> outputs 0 asynchronously, busy=0, done=0. Subsequent start -> full correct run.
